// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared fetch-stage constants: FSM state codes, Pcsrc codes, NOP.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DROP  = 1'b1;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0;

    // 01 is reserved and behaves like sequential.
    function automatic logic is_redirect(input logic [1:0] pcsrc);
        return (pcsrc == PCSRC_BR) || (pcsrc == PCSRC_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register; priority reset > flush > hold > load.
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            flush,
    input  logic            hold,
    input  logic            load,
    input  logic [PC_W-1:0] pc4_in,
    input  logic [31:0]     inst_in,
    output logic [PC_W-1:0] dPc4,
    output logic [31:0]     dInst,
    output logic            dValid
);

    logic [PC_W-1:0] r_pc4;
    logic [31:0]     r_inst;
    logic            r_valid;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (hold) begin
            r_pc4   <= r_pc4;
            r_inst  <= r_inst;
            r_valid <= r_valid;
        end else if (load) begin
            r_pc4   <= pc4_in;
            r_inst  <= inst_in;
            r_valid <= 1'b1;
        end else begin
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end
    end

    assign dPc4   = r_pc4;
    assign dInst  = r_inst;
    assign dValid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC, instruction-memory request port, next-PC select and IF/ID.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [1:0]      Pcsrc,
    input  logic [PC_W-1:0] Bpc,
    input  logic [PC_W-1:0] Jpc,
    input  logic            STALL,
    input  logic            Condep,
    output logic [PC_W-1:0] Iaddr,
    output logic            Ireq,
    input  logic            Irdy,
    input  logic [31:0]     Idata,
    output logic [PC_W-1:0] dPc4,
    output logic [31:0]     dInst,
    output logic            dValid
);

    localparam logic [PC_W-1:0] C_PC_STEP = PC_W'(4);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_rpc;
    logic [0:0]      r_state;
    logic            r_ireq;

    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_next_rpc;
    logic [0:0]      w_next_state;
    logic            w_redirect;
    logic            w_rdy;
    logic            w_fetch_ok;

    // A response only counts while our own request is outstanding.
    assign w_rdy      = Irdy & r_ireq;
    assign w_redirect = is_redirect(Pcsrc);
    assign w_target   = (Pcsrc == PCSRC_J) ? Jpc : Bpc;
    assign w_pc4      = r_pc + C_PC_STEP;

    always_comb begin
        w_next_pc    = r_pc;
        w_next_rpc   = r_rpc;
        w_next_state = r_state;
        w_fetch_ok   = 1'b0;
        if (r_state == DROP) begin
            if (w_redirect) begin
                w_next_rpc = w_target;
            end
            if (w_rdy) begin
                w_next_pc    = w_redirect ? w_target : r_rpc;
                w_next_state = FETCH;
            end
        end else begin
            if (w_redirect) begin
                if (w_rdy) begin
                    w_next_pc = w_target;
                end else begin
                    // In-flight response belongs to the old path; park the target.
                    w_next_rpc   = w_target;
                    w_next_state = DROP;
                end
            end else if (w_rdy && !STALL) begin
                w_next_pc  = w_pc4;
                w_fetch_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc    <= RESET_PC;
            r_rpc   <= '0;
            r_state <= FETCH;
            r_ireq  <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_rpc   <= w_next_rpc;
            r_state <= w_next_state;
            r_ireq  <= 1'b1;
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id (
        .Clk     (Clk),
        .Rst     (Rst),
        .flush   (~Condep),
        .hold    (STALL),
        .load    (w_fetch_ok),
        .pc4_in  (w_pc4),
        .inst_in (Idata),
        .dPc4    (dPc4),
        .dInst   (dInst),
        .dValid  (dValid)
    );

    assign Iaddr = r_pc;
    assign Ireq  = r_ireq;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, jpc;
    logic        stall, condep;
    logic [31:0] iaddr;
    logic        ireq;
    logic        irdy;
    logic [31:0] idata;
    logic [31:0] dpc4, dinst;
    logic        dvalid;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    // Memory: every word holds its own word index.
    assign idata = iaddr >> 2;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .Clk(clk), .Rst(rst), .Pcsrc(pcsrc), .Bpc(bpc), .Jpc(jpc),
        .STALL(stall), .Condep(condep), .Iaddr(iaddr), .Ireq(ireq),
        .Irdy(irdy), .Idata(idata), .dPc4(dpc4), .dInst(dinst), .dValid(dvalid)
    );

    // Behavioural model: PC, "outstanding fetch is stale" flag and pending target.
    logic [31:0] m_pc, m_pending, m_pc4, m_inst;
    bit          m_stale, m_ireq, m_valid;

    always @(posedge clk) begin : model
        bit          redirect, got, took;
        logic [31:0] target, next_pc;
        if (rst) begin
            m_pc = 32'h0; m_pending = 32'h0; m_stale = 0; m_ireq = 0;
            m_pc4 = 32'h0; m_inst = 32'h0; m_valid = 0;
        end else begin
            redirect = (pcsrc == 2'b10) || (pcsrc == 2'b11);
            target   = (pcsrc == 2'b11) ? jpc : bpc;
            got      = irdy && m_ireq;
            took     = 0;
            next_pc  = m_pc;
            if (m_stale) begin
                if (redirect) m_pending = target;
                if (got) begin
                    next_pc = m_pending;
                    m_stale = 0;
                end
            end else if (redirect) begin
                if (got) next_pc = target;
                else begin
                    m_pending = target;
                    m_stale   = 1;
                end
            end else if (got && !stall) begin
                took    = 1;
                next_pc = m_pc + 32'd4;
            end
            if (!condep) begin
                m_pc4 = 0; m_inst = 0; m_valid = 0;
            end else if (stall) begin
                // hold
            end else if (took) begin
                m_pc4 = m_pc + 32'd4; m_inst = m_pc >> 2; m_valid = 1;
            end else begin
                m_pc4 = 0; m_inst = 0; m_valid = 0;
            end
            m_pc   = next_pc;
            m_ireq = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        if (cmp_en) begin
            chk("m_iaddr", iaddr, m_pc);
            chk("m_ireq", {31'b0, ireq}, {31'b0, m_ireq});
            chk("m_dvalid", {31'b0, dvalid}, {31'b0, m_valid});
            chk("m_dinst", dinst, m_inst);
            chk("m_dpc4", dpc4, m_pc4);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; pcsrc = 2'b00; bpc = 0; jpc = 0; stall = 0; condep = 1; irdy = 1;
        cyc(); cyc();
        cmp_en = 1'b1;
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_ireq", {31'b0, ireq}, 32'h0);
        chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
        chk("rst_dinst", dinst, 32'h0);
        rst = 0;
        cyc(); chk("seq_ireq", {31'b0, ireq}, 32'h1); chk("seq_a0", iaddr, 32'h0);
        cyc(); chk("seq_a4", iaddr, 32'h4); chk("seq_pc4_4", dpc4, 32'h4);
               chk("seq_valid", {31'b0, dvalid}, 32'h1);
        cyc(); chk("seq_a8", iaddr, 32'h8); chk("seq_pc4_8", dpc4, 32'h8);
               chk("seq_inst1", dinst, 32'h1);
        stall = 1;
        cyc(); cyc();
        chk("stall_a8", iaddr, 32'h8); chk("stall_inst", dinst, 32'h1);
        stall = 0;
        cyc(); chk("resume_aC", iaddr, 32'hC); chk("resume_pc4C", dpc4, 32'hC);
               chk("resume_inst2", dinst, 32'h2);
        pcsrc = 2'b10; bpc = 32'h40; condep = 0; stall = 1;
        cyc(); chk("br_a40", iaddr, 32'h40); chk("br_flush", {31'b0, dvalid}, 32'h0);
               chk("br_nop", dinst, 32'h0);
        pcsrc = 2'b00; condep = 1; stall = 0;
        cyc(); chk("br_a44", iaddr, 32'h44); chk("br_inst10", dinst, 32'h10);
        irdy = 0;
        cyc(); chk("wait_bubble", {31'b0, dvalid}, 32'h0);
        cyc(); cyc(); chk("wait_a44", iaddr, 32'h44);
        pcsrc = 2'b11; jpc = 32'h100;
        cyc(); chk("drop1_a44", iaddr, 32'h44);
        pcsrc = 2'b10; bpc = 32'h200;
        cyc(); chk("drop2_a44", iaddr, 32'h44);
        pcsrc = 2'b00; irdy = 1;
        cyc(); chk("drop_a200", iaddr, 32'h200); chk("drop_discard", {31'b0, dvalid}, 32'h0);
        cyc(); chk("drop_inst80", dinst, 32'h80); chk("drop_pc4", dpc4, 32'h204);
               chk("drop_valid", {31'b0, dvalid}, 32'h1);
        irdy = 0; pcsrc = 2'b11; jpc = 32'h300;
        cyc();
        rst = 1; pcsrc = 2'b00; irdy = 1;
        cyc(); chk("rdrop_a0", iaddr, 32'h0); chk("rdrop_ireq", {31'b0, ireq}, 32'h0);
               chk("rdrop_valid", {31'b0, dvalid}, 32'h0); chk("rdrop_pc4", dpc4, 32'h0);
        rst = 0;
        cyc(); chk("late_rdy_noload", {31'b0, dvalid}, 32'h0); chk("late_a0", iaddr, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            int w;
            rst    = ($urandom_range(0, 99) == 0);
            irdy   = ($urandom_range(0, 9) < 7);
            stall  = ($urandom_range(0, 9) < 2);
            condep = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 15);
            pcsrc = (w == 10) ? 2'b01 : (w == 11 || w == 12) ? 2'b10 : (w == 13) ? 2'b11 : 2'b00;
            bpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
            jpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register feeding the decode-stage control unit of the pipelined CPU. The block holds the PC, drives a ready/valid-style instruction-memory port, and selects the next PC from the control unit's `Pcsrc`. It honours `STALL` (load-use hold) and `Condep` (low = flush after taken branch/jump). A small FSM discards a response that is already in flight when a redirect arrives.

## Interface
- `PC_W`, 32, PC/address width.
- `RESET_PC`, 0, PC value after reset.
- `Clk` in 1: sole clock, rising edge.
- `Rst` in 1: reset, synchronous, active-high.
- `Pcsrc` in 2: 00 = sequential; 10 = branch taken; 11 = jump; 01 = reserved, treated as 00.
- `Bpc` in PC_W: branch target.
- `Jpc` in PC_W: jump target.
- `STALL` in 1: hold the IF/ID register and the PC.
- `Condep` in 1: 0 = flush the IF/ID register this edge.
- `Iaddr` out PC_W: instruction address; always equals the PC register.
- `Ireq` out 1: fetch request outstanding.
- `Irdy` in 1: memory response valid this cycle; ignored while `Ireq`=0.
- `Idata` in 32: instruction word, valid when `Irdy`=1.
- `dPc4` out PC_W: PC+4 of the instruction held in IF/ID.
- `dInst` out 32: instruction held in IF/ID (NOP = 0).
- `dValid` out 1: IF/ID holds a real instruction.

## Operation
- Redirect = `Pcsrc` is 10 or 11. Target = `Bpc` for 10, `Jpc` for 11.
- Memory protocol: a request for `Iaddr` is issued while `Ireq`=1. `Iaddr` stays stable until the cycle in which `Irdy`=1. That cycle completes the request, and the next request starts on the following cycle.
- FSM states: FETCH (outstanding request is for the live PC) and DROP (outstanding request is stale; the register `Rpc` holds the pending target).
- FETCH, redirect with `Irdy`: PC <= target; data discarded; stay in FETCH.
- FETCH, redirect without `Irdy`: `Rpc` <= target; go to DROP; PC unchanged.
- FETCH, no redirect, `Irdy` and not `STALL`: PC <= PC+4; IF/ID <= {PC+4, `Idata`, valid=1}.
- FETCH, no redirect, `Irdy` and `STALL`: data discarded; PC holds; the same address is refetched.
- FETCH, no `Irdy`: PC holds.
- DROP, redirect: `Rpc` <= new target (latest wins).
- DROP, `Irdy`: data discarded; PC <= `Rpc`, or the new target if a redirect arrives in the same cycle; go to FETCH.
- IF/ID update priority at each edge:
  - `Rst`: clear.
  - else `Condep`=0: load NOP (valid=0), even if `STALL`=1.
  - else `STALL`: hold.
  - else a valid fetch completed in FETCH: load the fetched word.
  - else: load NOP (bubble).
- PC update priority: `Rst` > redirect > `STALL` > sequential.
- PC+4 wraps modulo 2^PC_W. Bits [1:0] of the PC are never checked.

## Timing
- Reset values: PC=`RESET_PC`, `Ireq`=0, `dInst`=0, `dPc4`=0, `dValid`=0, state FETCH, `Rpc`=0.
- `Ireq` is registered. It rises on the first edge after `Rst` deasserts and then stays at 1.
- With a zero-wait memory (`Irdy` tied to 1), throughput is one instruction per cycle. A word fetched at cycle n appears on `dInst` after edge n+1.
- A redirect presented in cycle n puts the target on `Iaddr` from n+1, when not in DROP and `Irdy`=1. In DROP, the target appears the cycle after the stale `Irdy`.
- Reset asserted mid-request or in DROP: the state returns to FETCH and `Ireq`=0. The memory must abandon the request; any `Irdy` seen while `Ireq`=0 is ignored.
- All outputs are registered except `Iaddr`, which is a direct copy of the PC register.

## Structure
- Shared package `cpu_pkg`: the state enum (FETCH, DROP), Pcsrc codes (`PCSRC_SEQ`=00, `PCSRC_BR`=10, `PCSRC_J`=11), and `NOP_INST`=32'h0.
- Sub-module `if_id_reg`: the IF/ID register with inputs `Rst`, flush, hold and load, implementing the priority list above.
- Top level holds the PC, `Rpc`, the FSM, and the next-PC mux.

## Test plan
- Reset, `RESET_PC`=0, `Irdy`=1, `Idata`=addr>>2 -> `Iaddr` 0, 4, 8 on consecutive cycles; `dPc4` 4, 8, C with `dValid`=1.
- `STALL`=1 for 2 cycles while at PC 8 -> `dInst` holds at 1; `Iaddr` stays 8; fetching resumes at 8 then C.
- `Pcsrc`=10, `Bpc`=40 with `Condep`=0 -> next `Iaddr`=40; IF/ID gets NOP with `dValid`=0, even with `STALL`=1.
- `Irdy`=0 for 3 cycles -> `Iaddr` constant; `dValid`=0 bubbles; no PC advance.
- `Irdy`=0, `Pcsrc`=11, `Jpc`=100, then `Pcsrc`=10, `Bpc`=200 next cycle, then `Irdy`=1 -> response discarded; next `Iaddr`=200; the word at 200 is the first valid instruction.
- `Rst` asserted in DROP -> all outputs at their reset values next cycle; `Ireq`=0; a late `Irdy` causes no IF/ID load.
